seq_mult_ctrl: RTL and testbench

Sequencing controller for the P-bit digit-serial signed multiplier datapath (seq_mult).
- Accepts one multiply request per valid/ready handshake.
- Drives the datapath control strobes (start, digit mux selects, Baugh-Wooley invert flags, column-end and flush strobes, placeOne).
- Walks the digit partial-product pairs column by column and flags each P-bit result digit on the datapath output as valid.

---
 rtl/seq_mult_pkg.sv | 30 +++
 rtl/seq_mult_pair_walker.sv | 46 ++++
 rtl/seq_mult_ctrl.sv | 110 +++++++++++
 tb/tb_seq_mult_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mult_pkg.sv
// Shared constants, state codes and digit-count helper for the seq_mult sequencing controller.
// Declarations only; no latency or flow control of its own.
package seq_mult_pkg;

  localparam int P           = 2;
  localparam int MAX_WIDTH   = 16;
  localparam int D_MAX       = MAX_WIDTH / P;
  localparam int BSW         = $clog2(D_MAX) + 2;
  localparam int SELW        = $clog2(D_MAX);
  localparam int DW          = SELW + 1;
  localparam int BITSIZE_MAX = 4;

  typedef logic [DW-1:0]   dcount_t;
  typedef logic [SELW-1:0] sel_t;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] FLUSH = 2'd3;

  // Digits per operand for a width code; 0 flags an illegal code.
  function automatic dcount_t digits_of(input logic [BSW-1:0] bs);
    dcount_t d;
    d = '0;
    if ((bs != '0) && (bs <= BSW'(BITSIZE_MAX)))
      d = dcount_t'(1) << (bs - BSW'(1));
    return d;
  endfunction

endpackage

// File: rtl/seq_mult_pair_walker.sv
// Column-by-column walk of digit pairs (i descending, j=k-i); outputs are combinational from the counters.
// Advances one pair per cycle while run is high, clears whenever run drops; no backpressure.
module seq_mult_pair_walker
  import seq_mult_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    run,
  input  dcount_t d,
  output sel_t    i,
  output sel_t    j,
  output dcount_t k,
  output logic    last_in_column,
  output logic    last_column
);

  dcount_t dm1;
  dcount_t i_lo;
  dcount_t k_nxt;
  dcount_t i_hi_nxt;

  // Lower bound of i in column k is max(0, k-D+1); next column starts at min(k+1, D-1).
  always_comb begin
    dm1      = d - dcount_t'(1);
    i_lo     = (k >= dm1) ? k - dm1 : '0;
    k_nxt    = k + dcount_t'(1);
    i_hi_nxt = (k_nxt > dm1) ? dm1 : k_nxt;
  end

  assign j              = sel_t'(k - {1'b0, i});
  assign last_in_column = ({1'b0, i} == i_lo);
  assign last_column    = (k == {dm1[DW-2:0], 1'b0});

  always_ff @(posedge clk) begin
    if (rst || !run) begin
      k <= '0;
      i <= '0;
    end else if (last_in_column) begin
      k <= k_nxt;
      i <= sel_t'(i_hi_nxt);
    end else begin
      i <= i - sel_t'(1);
    end
  end

endmodule

// File: rtl/seq_mult_ctrl.sv
// Sequencing controller for the digit-serial signed multiplier: strobes, pair walk, digit-valid flags.
// Accept to out_last is D^2+3 cycles; one job at a time via req_ready, result digits never stall.
module seq_mult_ctrl
  import seq_mult_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           abort,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [BSW-1:0] req_bitsize,
  output logic           busy,
  output logic           start,
  output logic [BSW-1:0] bitSize,
  output sel_t           muxSelA,
  output sel_t           muxSelB,
  output logic           invertFirstBit,
  output logic           invertSecondRow,
  output logic           countDown,
  output logic           countLast2,
  output logic           lastOut,
  output logic           placeOne,
  output logic           out_valid,
  output dcount_t        out_idx,
  output logic           out_last,
  output logic           err
);

  logic [1:0] state;
  logic       run;
  dcount_t    d;
  dcount_t    dm1;
  sel_t       dm1_s;
  sel_t       wi;
  sel_t       wj;
  dcount_t    wk;
  logic       lic;
  logic       lcol;

  assign run   = (state == RUN);
  assign d     = digits_of(bitSize);
  assign dm1   = d - dcount_t'(1);
  assign dm1_s = sel_t'(dm1);

  seq_mult_pair_walker u_walker (
    .clk            (clk),
    .rst            (rst),
    .run            (run && !abort),
    .d              (d),
    .i              (wi),
    .j              (wj),
    .k              (wk),
    .last_in_column (lic),
    .last_column    (lcol)
  );

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state     <= IDLE;
      bitSize   <= '0;
      err       <= 1'b0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else begin
      err       <= 1'b0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            bitSize <= req_bitsize;
            if (digits_of(req_bitsize) != '0) state <= LOAD;
            else                              err   <= 1'b1;
          end
        end
        LOAD: state <= RUN;
        RUN: begin
          if (lic) begin
            out_valid <= 1'b1;
            out_idx   <= wk;
            if (lcol) state <= FLUSH;
          end
        end
        FLUSH: begin
          out_valid <= 1'b1;
          out_idx   <= {dm1[DW-2:0], 1'b1};
          out_last  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready       = (state == IDLE);
  assign busy            = (state != IDLE);
  assign start           = (state == LOAD);
  assign lastOut         = (state == FLUSH);
  assign muxSelA         = run ? wi : '0;
  assign muxSelB         = run ? wj : '0;
  assign invertSecondRow = run && (wi == dm1_s) && (wj != dm1_s);
  assign invertFirstBit  = run && (wj == dm1_s) && (wi != dm1_s);
  assign countDown       = run && (wk >= dm1);
  assign countLast2      = run && lic;
  // Sizes below 16 bits get their constant one from datapath init instead.
  assign placeOne        = countLast2 && (bitSize == BSW'(BITSIZE_MAX)) && (wk == dm1);

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Self-checking bench for seq_mult_ctrl: vector table, hand corner sequences, random jobs vs a pair-list model.
module tb_seq_mult_ctrl;
  import seq_mult_pkg::*;

  logic           clk = 1'b0;
  logic           rst, abort, req_valid, req_ready;
  logic [BSW-1:0] req_bitsize, bitSize;
  logic           busy, start, invertFirstBit, invertSecondRow;
  logic           countDown, countLast2, lastOut, placeOne;
  logic           out_valid, out_last, err;
  logic [2:0]     muxSelA, muxSelB;
  logic [3:0]     out_idx;

  always #5 clk = ~clk;

  seq_mult_ctrl dut (
    .clk(clk), .rst(rst), .abort(abort), .req_valid(req_valid), .req_ready(req_ready),
    .req_bitsize(req_bitsize), .busy(busy), .start(start), .bitSize(bitSize),
    .muxSelA(muxSelA), .muxSelB(muxSelB), .invertFirstBit(invertFirstBit),
    .invertSecondRow(invertSecondRow), .countDown(countDown), .countLast2(countLast2),
    .lastOut(lastOut), .placeOne(placeOne), .out_valid(out_valid), .out_idx(out_idx),
    .out_last(out_last), .err(err)
  );

  typedef struct packed {
    logic       rdy;
    logic       busy;
    logic       start;
    logic [2:0] a;
    logic [2:0] b;
    logic       ifb;
    logic       isr;
    logic       cd;
    logic       cl2;
    logic       lo;
    logic       po;
    logic       ov;
    logic [3:0] oidx;
    logic       olast;
    logic       err;
  } obs_t;

  typedef struct {
    int bs;
    int run_cyc;
    int cl2;
    int po;
    int err;
  } vec_t;

  int     checks = 0;
  int     errors = 0;
  obs_t   exp_q[$];
  obs_t   cap[0:127];
  int     n_run, n_cl2, n_po, n_err;
  longint acc;

  function automatic obs_t observe();
    obs_t o;
    o.rdy = req_ready; o.busy = busy; o.start = start; o.a = muxSelA; o.b = muxSelB;
    o.ifb = invertFirstBit; o.isr = invertSecondRow; o.cd = countDown; o.cl2 = countLast2;
    o.lo = lastOut; o.po = placeOne; o.ov = out_valid; o.oidx = out_idx;
    o.olast = out_last; o.err = err;
    return o;
  endfunction

  function automatic obs_t idle_obs();
    obs_t o;
    o = '0;
    o.rdy = 1'b1;
    return o;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_obs(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int digits(input int bs);
    return (bs >= 1 && bs <= 4) ? (1 << (bs - 1)) : 0;
  endfunction

  // Signed-digit value: only the top digit of an operand carries sign.
  function automatic longint digit_val(input longint v, input int idx, input int d);
    longint x;
    x = (v >>> (2 * idx)) & 64'd3;
    if (idx == d - 1 && x >= 2) x -= 4;
    return x;
  endfunction

  function automatic longint rand_op(input int d);
    int w;
    if (d == 0) return 0;
    w = 2 * d;
    return longint'($urandom_range(0, (1 << w) - 1)) - (longint'(1) << (w - 1));
  endfunction

  // Expected per-cycle trace, cycle 1 (after accept) through the out_last cycle.
  task automatic build_model(input int bs);
    obs_t o;
    int   d, hi, lo, pend_ov, pend_idx;
    exp_q.delete();
    d = digits(bs);
    if (d == 0) begin
      o = idle_obs(); o.err = 1'b1; exp_q.push_back(o);
      exp_q.push_back(idle_obs());
      return;
    end
    o = '0; o.busy = 1'b1; o.start = 1'b1; exp_q.push_back(o);
    pend_ov = 0; pend_idx = 0;
    for (int k = 0; k <= 2 * d - 2; k++) begin
      hi = (k < d - 1) ? k : d - 1;
      lo = (k - d + 1 > 0) ? k - d + 1 : 0;
      for (int i = hi; i >= lo; i--) begin
        o = '0;
        o.busy = 1'b1;
        o.a    = 3'(i);
        o.b    = 3'(k - i);
        o.isr  = (i == d - 1) && (k - i != d - 1);
        o.ifb  = (k - i == d - 1) && (i != d - 1);
        o.cd   = (k >= d - 1);
        o.cl2  = (i == lo);
        o.po   = o.cl2 && bs == 4 && k == d - 1;
        o.ov   = pend_ov[0];
        o.oidx = pend_ov != 0 ? 4'(pend_idx) : 4'd0;
        exp_q.push_back(o);
        pend_ov  = (i == lo) ? 1 : 0;
        pend_idx = k;
      end
    end
    o = '0; o.busy = 1'b1; o.lo = 1'b1; o.ov = pend_ov[0]; o.oidx = 4'(pend_idx);
    exp_q.push_back(o);
    o = idle_obs(); o.ov = 1'b1; o.oidx = 4'(2 * d - 1); o.olast = 1'b1;
    exp_q.push_back(o);
  endtask

  // Called and returns on a negedge; the caller's negedge is cycle 0 (accept).
  task automatic run_job(input int bs, input longint a, input longint b);
    obs_t o;
    int   d;
    build_model(bs);
    d = digits(bs);
    req_valid = 1'b1;
    req_bitsize = BSW'(bs);
    n_run = 0; n_cl2 = 0; n_po = 0; n_err = 0; acc = 0;
    for (int c = 1; c <= exp_q.size(); c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      o = observe();
      cap[c] = o;
      chk_obs($sformatf("bs%0d_cyc%0d", bs, c), o, exp_q[c-1]);
      if (o.busy && !o.start && !o.lo) begin
        n_run++;
        acc += digit_val(a, int'(o.a), d) * digit_val(b, int'(o.b), d)
               * (longint'(1) << (2 * (int'(o.a) + int'(o.b))));
      end
      if (o.cl2) n_cl2++;
      if (o.po)  n_po++;
      if (o.err) n_err++;
    end
    chk($sformatf("bitSize_bs%0d", bs), longint'(bitSize), bs);
    if (d > 0) chk($sformatf("product_bs%0d", bs), acc, a * b);
  endtask

  task automatic abort_job(input bit use_rst);
    req_valid = 1'b1;
    req_bitsize = BSW'(3);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk(use_rst ? "rst_at_cl2" : "abort_at_cl2", longint'(countLast2), 1);
    if (use_rst) rst = 1'b1;
    else         abort = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    abort = 1'b0;
    chk_obs(use_rst ? "rst_idle" : "abort_idle", observe(), idle_obs());
    chk(use_rst ? "rst_bitsize" : "abort_bitsize", longint'(bitSize), 0);
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      chk_obs($sformatf("%s_quiet%0d", use_rst ? "rst" : "abort", t), observe(), idle_obs());
    end
    run_job(3, rand_op(4), rand_op(4));
  endtask

  vec_t vt[6];

  initial begin
    vt[0] = '{0, 0,  0, 0, 1};
    vt[1] = '{1, 1,  1, 0, 0};
    vt[2] = '{2, 4,  3, 0, 0};
    vt[3] = '{3, 16, 7, 0, 0};
    vt[4] = '{4, 64, 15, 1, 0};
    vt[5] = '{5, 0,  0, 0, 1};

    rst = 1'b1; abort = 1'b0; req_valid = 1'b0; req_bitsize = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      chk_obs($sformatf("reset_idle%0d", t), observe(), idle_obs());
    end
    chk("reset_bitsize", longint'(bitSize), 0);

    for (int t = 0; t < 6; t++) begin
      run_job(vt[t].bs, rand_op(digits(vt[t].bs)), rand_op(digits(vt[t].bs)));
      chk($sformatf("vec%0d_run", t), n_run, vt[t].run_cyc);
      chk($sformatf("vec%0d_cl2", t), n_cl2, vt[t].cl2);
      chk($sformatf("vec%0d_po", t), n_po, vt[t].po);
      chk($sformatf("vec%0d_err", t), n_err, vt[t].err);
    end

    // D=2 cycle-by-cycle, against fixed values.
    run_job(2, 5, -3);
    chk("d2_start", cap[1].start, 1);
    for (int c = 2; c <= 5; c++) begin
      chk($sformatf("d2_a%0d", c), cap[c].a, (c == 3 || c == 5) ? 1 : 0);
      chk($sformatf("d2_b%0d", c), cap[c].b, (c >= 4) ? 1 : 0);
      chk($sformatf("d2_cl2_%0d", c), cap[c].cl2, (c != 3) ? 1 : 0);
    end
    chk("d2_isr3", cap[3].isr, 1);
    chk("d2_ifb3", cap[3].ifb, 0);
    chk("d2_ifb4", cap[4].ifb, 1);
    chk("d2_isr4", cap[4].isr, 0);
    chk("d2_lastout6", cap[6].lo, 1);
    for (int c = 2; c <= 7; c++)
      chk($sformatf("d2_ov%0d", c), cap[c].ov, (c == 2 || c == 4) ? 0 : 1);
    chk("d2_idx3", cap[3].oidx, 0);
    chk("d2_idx5", cap[5].oidx, 1);
    chk("d2_idx6", cap[6].oidx, 2);
    chk("d2_idx7", cap[7].oidx, 3);
    chk("d2_last7", cap[7].olast, 1);

    // 16-bit corner operands and column-7 strobes.
    run_job(4, -32768, -32768);
    chk("min_sq_value", acc, 64'h40000000);
    chk("cd_before_col7", cap[29].cd, 0);
    chk("cd_at_col7", cap[30].cd, 1);
    chk("placeone_col7", cap[37].po, 1);
    run_job(4, 1234, -567);
    chk("mixed_value", acc, -699678);

    // 2-bit jobs back to back; second accepted in the first one's out_last cycle.
    run_job(1, -2, 1);
    chk("b1_ov3", cap[3].ov, 1);
    chk("b1_idx3", cap[3].oidx, 0);
    chk("b1_ov4_last", {cap[4].ov, cap[4].olast}, 3);
    chk("b1_idx4", cap[4].oidx, 1);
    run_job(1, -1, -2);
    chk("b2b_start", cap[1].start, 1);

    abort_job(1'b0);
    abort_job(1'b1);

    for (int r = 0; r < 16; r++) begin
      automatic int bs  = $urandom_range(0, 5);
      automatic int gap = $urandom_range(0, 2);
      run_job(bs, rand_op(digits(bs)), rand_op(digits(bs)));
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        chk_obs($sformatf("gap%0d_%0d", r, g), observe(), idle_obs());
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
